// File: rtl/seg_reader.sv
// Seven-segment bus reader: filters the sampled glyph for stability and returns its hex value on valid/ready.
// Optional SEG_READER_ERR_EN adds the err pulse output for qualified unrecognised glyphs.
module seg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  input  logic F,
  input  logic G,
  input  logic DP,
  input  logic digit,
  input  logic ready,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic dp_out,
  output logic valid
`ifdef SEG_READER_ERR_EN
  ,
  output logic err
`endif
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    last_q, last_d;
  logic          last_v_q, last_v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    hex_q, hex_d;
  logic          dp_q, dp_d;
  logic          valid_q, valid_d;
`ifdef SEG_READER_ERR_EN
  logic          err_q, err_d;
`endif

  logic [7:0]    sample_c;
  logic [4:0]    decode_c;

  assign sample_c = {A, B, C, D, E, F, G, DP};

  // Returns {recognised, hex} for a {A..G} pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   decode = {1'b1, 4'h0};
      7'h30:   decode = {1'b1, 4'h1};
      7'h6D:   decode = {1'b1, 4'h2};
      7'h79:   decode = {1'b1, 4'h3};
      7'h33:   decode = {1'b1, 4'h4};
      7'h5B:   decode = {1'b1, 4'h5};
      7'h5F:   decode = {1'b1, 4'h6};
      7'h70:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h7B:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h1F:   decode = {1'b1, 4'hB};
      7'h4E:   decode = {1'b1, 4'hC};
      7'h3D:   decode = {1'b1, 4'hD};
      7'h4F:   decode = {1'b1, 4'hE};
      7'h47:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  assign decode_c = decode(sample_c[7:1]);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    last_d   = last_q;
    last_v_d = last_v_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
`ifdef SEG_READER_ERR_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        seg_d    = sample_c;
        cnt_d    = '0;
        last_v_d = 1'b0;
        if (digit) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(1);
        end
      end
      ST_SETTLE: begin
        seg_d = sample_c;
        if (!digit) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          last_v_d = 1'b0;
        end else begin
          if (sample_c != seg_q) begin
            cnt_d = CW'(1);
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
          // A count of STABLE_CYCLES (>=2) implies sample_c == seg_q.
          if (cnt_d == CNT_MAX && (!last_v_q || sample_c != last_q)) begin
            if (decode_c[4]) begin
              hex_d   = decode_c[3:0];
              dp_d    = sample_c[0];
              valid_d = 1'b1;
              state_d = ST_PRESENT;
            end else begin
              last_d   = sample_c;
              last_v_d = 1'b1;
`ifdef SEG_READER_ERR_EN
              err_d    = 1'b1;
`endif
            end
          end
        end
      end
      ST_PRESENT: begin
        cnt_d = '0;
        if (ready) begin
          valid_d  = 1'b0;
          last_d   = seg_q;
          last_v_d = digit;
          state_d  = digit ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        last_v_d = 1'b0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      seg_q    <= '0;
      last_q   <= '0;
      last_v_q <= 1'b0;
      cnt_q    <= '0;
      hex_q    <= '0;
      dp_q     <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SEG_READER_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      last_q   <= last_d;
      last_v_q <= last_v_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      dp_q     <= dp_d;
      valid_q  <= valid_d;
`ifdef SEG_READER_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign {a, b, c, d} = hex_q;
  assign dp_out       = dp_q;
  assign valid        = valid_q;
`ifdef SEG_READER_ERR_EN
  assign err          = err_q;
`endif

endmodule
